// File: rtl/trace_delta_decoder_pkg.sv
// Shared types and helpers for the trace change-record decoder.
package trace_decoder_pkg;

  localparam int unsigned MAX_VARS = 256;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    CHECK  = 2'd1,
    REPORT = 2'd2
  } state_e;

  // Expected shadow row: even-numbered variables are 1, odd ones are 0.
  function automatic logic [MAX_VARS-1:0] expect_mask(input int unsigned vars);
    logic [MAX_VARS-1:0] m;
    m = '0;
    for (int unsigned v = 0; v < MAX_VARS; v++) begin
      if (v < vars && (v % 2) == 0) m[v] = 1'b1;
    end
    return m;
  endfunction

  // Add b to a, clamping at the all-ones value of a w-bit counter (w <= 31).
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] max_v;
    sum   = {1'b0, a} + {1'b0, b};
    max_v = (33'd1 << w) - 33'd1;
    return (sum > max_v) ? max_v[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/trace_delta_decoder_if.sv
// Change-record stream: one record per valid/ready handshake.
interface trace_delta_decoder_if #(
  parameter int unsigned INSTANCES = 10,
  parameter int unsigned VARS      = 10
) ();
  localparam int unsigned IW = (INSTANCES > 1) ? $clog2(INSTANCES) : 1;
  localparam int unsigned VW = (VARS > 1) ? $clog2(VARS) : 1;

  logic          rec_valid;
  logic          rec_ready;
  logic [IW-1:0] rec_inst;
  logic [VW-1:0] rec_var;
  logic          rec_value;
  logic          rec_last;

  modport master (output rec_valid, rec_inst, rec_var, rec_value, rec_last,
                  input  rec_ready);
  modport slave  (input  rec_valid, rec_inst, rec_var, rec_value, rec_last,
                  output rec_ready);
endinterface

// File: rtl/trace_delta_decoder_row_popcount.sv
// Combinational population count of one shadow row.
module trace_row_popcount #(
  parameter int unsigned VARS = 10
) (
  input  logic [VARS-1:0]              row_i,
  output logic [$clog2(VARS+1)-1:0]    count_o
);
  localparam int unsigned PW = $clog2(VARS + 1);

  always_comb begin
    count_o = '0;
    for (int unsigned i = 0; i < VARS; i++) begin
      count_o = count_o + PW'(row_i[i]);
    end
  end
endmodule

// File: rtl/trace_delta_decoder.sv
// Rebuilds an INSTANCES x VARS shadow bank from change records and checks it per timestep.
// Optional TRACE_DECODER_CHANGE_ONLY_EN: redundant (no-change) records count as errors.
module trace_delta_decoder
  import trace_decoder_pkg::*;
#(
  parameter int unsigned INSTANCES = 10,
  parameter int unsigned VARS      = 10,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  trace_delta_decoder_if.slave      rec,
  output logic                      check_done,
  output logic                      check_pass,
  output logic                      range_err,
  output logic [CNT_W-1:0]          frame_count,
  output logic [CNT_W-1:0]          err_count
);
  localparam int unsigned IW = (INSTANCES > 1) ? $clog2(INSTANCES) : 1;
  localparam int unsigned PW = $clog2(VARS + 1);
  localparam int unsigned AW = $clog2(INSTANCES * VARS + 1);
  localparam logic [MAX_VARS-1:0] MASK_FULL   = expect_mask(VARS);
  localparam logic [VARS-1:0]     EXPECT_MASK = MASK_FULL[VARS-1:0];
  localparam logic [IW-1:0]       LAST_ROW    = IW'(INSTANCES - 1);

  state_e            state_q, state_d;
  logic [VARS-1:0]   shadow_q [INSTANCES];
  logic [VARS-1:0]   shadow_d [INSTANCES];
  logic [IW-1:0]     row_q, row_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic              range_q, range_d;
  logic              kill_q, kill_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CNT_W-1:0]  frame_q, frame_d;
  logic [CNT_W-1:0]  err_q, err_d;

  logic [PW-1:0]     row_pc;
  logic              accept;
  logic              in_range;

  trace_row_popcount #(.VARS(VARS)) u_popcount (
    .row_i   (shadow_q[row_q] ^ EXPECT_MASK),
    .count_o (row_pc)
  );

  assign accept   = rec.rec_valid && ready_q;
  assign in_range = (32'(rec.rec_inst) < INSTANCES) && (32'(rec.rec_var) < VARS);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    row_d    = row_q;
    acc_d    = acc_q;
    range_d  = range_q;
    kill_d   = kill_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    frame_d  = frame_q;
    err_d    = err_q;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (!in_range) begin
            range_d = 1'b1;
            err_d   = CNT_W'(sat_add(32'(err_q), 32'd1, CNT_W));
          end else begin
`ifdef TRACE_DECODER_CHANGE_ONLY_EN
            if (shadow_q[rec.rec_inst][rec.rec_var] == rec.rec_value) begin
              err_d  = CNT_W'(sat_add(32'(err_q), 32'd1, CNT_W));
              kill_d = 1'b1;
            end
`endif
            shadow_d[rec.rec_inst][rec.rec_var] = rec.rec_value;
          end
          if (rec.rec_last) begin
            state_d = CHECK;
            row_d   = '0;
          end
        end
      end
      CHECK: begin
        acc_d = acc_q + AW'(row_pc);
        if (row_q == LAST_ROW) state_d = REPORT;
        else                   row_d   = row_q + 1'b1;
      end
      REPORT: begin
        done_d  = 1'b1;
        pass_d  = (acc_q == '0) && !range_q && !kill_q;
        err_d   = CNT_W'(sat_add(32'(err_q), 32'(acc_q), CNT_W));
        frame_d = frame_q + 1'b1;
        range_d = 1'b0;
        kill_d  = 1'b0;
        acc_d   = '0;
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase

    ready_d = (state_d == ACCUM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      for (int unsigned i = 0; i < INSTANCES; i++) shadow_q[i] <= '0;
      row_q   <= '0;
      acc_q   <= '0;
      range_q <= 1'b0;
      kill_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      frame_q <= '0;
      err_q   <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      row_q    <= row_d;
      acc_q    <= acc_d;
      range_q  <= range_d;
      kill_q   <= kill_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
    end
  end

  assign rec.rec_ready = ready_q;
  assign check_done    = done_q;
  assign check_pass    = pass_q;
  assign range_err     = range_q;
  assign frame_count   = frame_q;
  assign err_count     = err_q;

endmodule

// File: tb/tb_trace_delta_decoder.sv
// Directed bench for trace_delta_decoder with 4-bit counters to reach wrap/saturation quickly.
module tb_trace_delta_decoder;
  localparam int unsigned INSTANCES = 10;
  localparam int unsigned VARS      = 10;
  localparam int unsigned CNT_W     = 4;
`ifdef TRACE_DECODER_CHANGE_ONLY_EN
  localparam int CO = 1;
`else
  localparam int CO = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             check_done, check_pass, range_err;
  logic [CNT_W-1:0] frame_count, err_count;
  int               checks = 0;
  int               errors = 0;
  int               lat, st;

  trace_delta_decoder_if #(.INSTANCES(INSTANCES), .VARS(VARS)) rec_if ();

  trace_delta_decoder #(.INSTANCES(INSTANCES), .VARS(VARS), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .rec         (rec_if),
    .check_done  (check_done),
    .check_pass  (check_pass),
    .range_err   (range_err),
    .frame_count (frame_count),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Drives one record and returns after the accepting edge (+1); stalls = edges spent waiting.
  task automatic send(input int i, input int v, input logic val, input logic last,
                      output int stalls);
    logic rdy;
    stalls = 0;
    rec_if.rec_valid = 1'b1;
    rec_if.rec_inst  = 4'(i);
    rec_if.rec_var   = 4'(v);
    rec_if.rec_value = val;
    rec_if.rec_last  = last;
    forever begin
      rdy = rec_if.rec_ready;
      @(posedge clk); #1;
      if (rdy) break;
      stalls++;
      if (stalls >= 200) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    rec_if.rec_valid = 1'b0;
    rec_if.rec_last  = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!check_done && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic frame_result(input string tag, input int pass_e, input int err_e,
                              input int frame_e);
    wait_done(lat);
    chk({tag, "_lat"}, lat, 11);
    chk({tag, "_pass"}, check_pass, pass_e);
    chk({tag, "_err"}, err_count, err_e);
    chk({tag, "_frame"}, frame_count, frame_e);
  endtask

  initial begin
    rst = 1'b1;
    rec_if.rec_valid = 1'b0;
    rec_if.rec_inst  = '0;
    rec_if.rec_var   = '0;
    rec_if.rec_value = 1'b0;
    rec_if.rec_last  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", rec_if.rec_ready, 0);
    chk("rst_done", check_done, 0);
    chk("rst_pass", check_pass, 0);
    chk("rst_range", range_err, 0);
    chk("rst_frame", frame_count, 0);
    chk("rst_err", err_count, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", rec_if.rec_ready, 1);

    // Frame 1: every even var set, exact match
    for (int i = 0; i < 10; i++)
      for (int v = 0; v < 10; v += 2)
        send(i, v, 1'b1, (i == 9 && v == 8), st);
    frame_result("exact", 1, 0, 1);
    @(posedge clk); #1;
    chk("done_pulse", check_done, 0);
    chk("pass_held", check_pass, 1);

    // Frame 2: single mismatching bit
    send(3, 4, 1'b0, 1'b1, st);
    frame_result("mismatch", 0, 1, 2);

    // Frame 3: out-of-range instance dropped; earlier mismatch still present
    send(12, 0, 1'b1, 1'b1, st);
    chk("range_set", range_err, 1);
    frame_result("range", 0, 3, 3);
    @(posedge clk); #1;
    chk("range_clear", range_err, 0);

    // Frame 4 restores the bit; frame 5's record is held through frame 4's scan
    send(3, 4, 1'b1, 1'b1, st);
    chk("ready_low_check", rec_if.rec_ready, 0);
    send(5, 1, 1'b1, 1'b1, st);
    chk("stall_cycles", st, 11);
    chk("f4_pass", check_pass, 1);
    chk("f4_err", err_count, 3);
    chk("f4_frame", frame_count, 4);
    frame_result("bp", 0, 4, 5);
    repeat (15) @(posedge clk);
    #1;
    chk("no_dup_frame", frame_count, 5);

    send(5, 1, 1'b0, 1'b1, st);
    frame_result("restore", 1, 4, 6);

    // Frame 7: rewrite an already-set bit
    send(0, 0, 1'b1, 1'b1, st);
    frame_result("redundant", 1 - CO, 4 + CO, 7);

    // Frame 8: 20 mismatching bits saturate err_count
    for (int i = 0; i < 10; i++) begin
      send(i, 1, 1'b1, 1'b0, st);
      send(i, 3, 1'b1, (i == 9), st);
    end
    frame_result("sat", 0, 15, 8);

    send(12, 0, 1'b0, 1'b1, st);
    frame_result("sat_drop", 0, 15, 9);

    // Frames 10..16: frame_count wraps to 0 at the 16th
    for (int f = 10; f <= 16; f++) begin
      send(0, 0, 1'b1, 1'b1, st);
      wait_done(lat);
      if (f == 15) chk("frame_15", frame_count, 15);
    end
    chk("frame_wrap", frame_count, 0);
    chk("err_hold", err_count, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/trace_delta_decoder.md
Name: trace_delta_decoder

Overview:
- Consumer side of a trace change-record stream. Each record says "instance I, variable V now holds value B".
- Rebuilds a shadow bank of INSTANCES x VARS one-bit signals from those records.
- At every timestep boundary it checks the shadow bank against the expected pattern: bit v = 1 when v is even.
- Sits in regression benches downstream of the trace-combine stimulus. Reports pass/fail per timestep plus running counters.

Parameters:
- INSTANCES, 10, number of instance rows; at least 1.
- VARS, 10, one-bit variables per instance; at least 1.
- CNT_W, 16, width of the frame and error counters.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rec_valid  in  1  a change record is presented.
- rec_ready  out  1  the decoder can accept a record.
- rec_inst  in  $clog2(INSTANCES) (min 1)  instance index of the record.
- rec_var  in  $clog2(VARS) (min 1)  variable index of the record.
- rec_value  in  1  new value of the variable.
- rec_last  in  1  this record closes the current timestep.
- check_done  out  1  one-cycle pulse; the check result is valid.
- check_pass  out  1  result of the last completed check; held until the next check_done.
- range_err  out  1  sticky: an index was out of range during the current frame.
- frame_count  out  CNT_W  number of completed checks; wraps to 0.
- err_count  out  CNT_W  total mismatching bits plus dropped records; saturates at all-ones.

Behaviour:
- Reset:
  - All registers clear: shadow bank 0, rec_ready 0, check_done 0, check_pass 0, range_err 0, both counters 0.
  - State goes to ACCUM.
  - rst asserted mid-CHECK abandons the scan. No check_done is produced.
- States: ACCUM -> CHECK -> REPORT -> ACCUM.
- ACCUM:
  - rec_ready = 1.
  - A record is accepted only when rec_valid and rec_ready are both 1.
  - When accepted, shadow[rec_inst][rec_var] <= rec_value, visible the next cycle.
  - If rec_inst >= INSTANCES or rec_var >= VARS: the shadow bank is unchanged, range_err is set, err_count += 1.
  - An accepted record with rec_last = 1 is applied (or dropped) first, then the state moves to CHECK.
  - rec_last only counts on an accepted record.
- CHECK:
  - rec_ready = 0.
  - Scans one instance row per cycle, rows 0..INSTANCES-1, so CHECK lasts exactly INSTANCES cycles.
  - For each row: mismatches = popcount(row XOR EXPECT_MASK), added to a per-frame accumulator.
- REPORT (1 cycle):
  - check_done = 1.
  - check_pass = (accumulator == 0) and no range_err.
  - err_count += accumulator, saturating.
  - frame_count += 1, wrapping.
  - range_err and the accumulator clear on the next cycle.
  - The shadow bank persists across frames.
  - Returns to ACCUM.
- Latency: from the accepting edge of the rec_last record, check_done is high INSTANCES + 1 cycles later.
- Records presented during CHECK/REPORT stall. rec_valid and the payload must hold until accepted.

Optional Feature:
- Macro: TRACE_DECODER_CHANGE_ONLY_EN.
- Defined: an in-range record whose rec_value equals the current shadow bit is a redundant change. It is still accepted, but err_count += 1 and that frame's check_pass is forced to 0.
- Not defined: redundant records are accepted silently, with no counter effect.

Decomposition:
- Package trace_decoder_pkg holds:
  - state enum {ACCUM, CHECK, REPORT};
  - function expect_mask(VARS) returning bit v = (v % 2 == 0);
  - saturating-add function for CNT_W counters.
- One sub-module, trace_row_popcount: combinational popcount of a VARS-bit vector, output width $clog2(VARS+1).

Test Plan:
- Reset check: hold rst for 3 cycles. All outputs are 0. rec_ready goes 1 on the first cycle after rst falls.
- Exact pattern:
  - Send 50 records setting every even var of instances 0..9 to 1; the last has rec_last=1.
  - check_done pulses 11 cycles after the last handshake.
  - check_pass=1, frame_count=1, err_count=0.
- Mismatch:
  - Next frame, one record (inst 3, var 4, value 0, rec_last=1).
  - check_pass=0, err_count=1, frame_count=2.
- Range error:
  - Record inst 12, var 0, rec_last=1.
  - Shadow unchanged; range_err=1 before check_done.
  - check_pass=0, err_count +1 (the dropped record) plus the carried mismatch count.
- Backpressure: hold rec_valid high throughout CHECK. rec_ready stays 0 for 11 cycles, the record is accepted on the first ACCUM cycle, and no record is lost or duplicated.
- Counter boundaries:
  - With CNT_W=4, run 16 frames: frame_count wraps to 0.
  - Force more than 15 errors: err_count holds at 15.
  - With TRACE_DECODER_CHANGE_ONLY_EN, rewriting inst 0, var 0 with 1 adds 1 to err_count and gives check_pass=0.
